smart_cargo_tx_status: RTL and testbench
========================================

Name: smart_cargo_tx_status

Overview:
UART 8N1 transmitter that returns cargo-elevator status to the host, the opposite direction of the existing RX command path. On request it snapshots the current floor, next stop, motor flags, emergency and the motion-FSM state. It then serialises a fixed 4-byte status frame on TX. It sits beside the datapath in smart_cargo and is fed from the andarAtual, proxParada, motor and Eatual1_db signals.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); legal range 2 or more.
FRAME_HDR, 8'h53, header byte ('S').

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
enviar  input  1  request a status frame; level-sampled each cycle.
andarAtual  input  2  current floor.
proxParada  input  2  next stop.
motorSubindo  input  1  motor up.
motorDescendo  input  1  motor down.
emergencia  input  1  emergency active.
estado_mov  input  4  motion-FSM state code.
TX  output  1  serial line; idle high.
ocupado  output  1  high while a frame is in progress.
pronto  output  1  one-cycle pulse when a frame completes.
db_estado  output  3  frame-FSM state code, for debug.

Behaviour:
- Reset (reset=0, asynchronous): TX=1, ocupado=0, pronto=0, pendente=0, FSM=OCIOSO, db_estado=0. If reset hits mid-frame, TX returns high immediately and the partial frame is abandoned.
- Frame contents, captured in one cycle at acceptance:
  - b0 = FRAME_HDR.
  - b1 = {emergencia, motorSubindo, motorDescendo, 1'b0, proxParada, andarAtual}.
  - b2 = {4'h0, estado_mov}.
  - b3 = b0 ^ b1 ^ b2.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame-FSM states (db_estado code):
  - OCIOSO(0): if enviar=1, snapshot the inputs, set idx=0, ocupado=1, go to CARREGA.
  - CARREGA(1): load byte[idx] into the sub-module and pulse partida for one cycle; go to ESPERA.
  - ESPERA(2): wait for pronto_byte. On pronto_byte, if idx<3 then idx++ and go to CARREGA; otherwise go to FIM.
  - FIM(3): pronto=1 for one cycle, ocupado=0. If pendente=1, clear pendente and go to CARREGA with a fresh snapshot and idx=0, keeping ocupado=1 and the pronto pulse. Otherwise go to OCIOSO.
- Latency:
  - enviar sampled at edge N, so the TX start bit begins at edge N+2.
  - Between bytes, TX stays idle-high for exactly 1 cycle after the stop bit (the CARREGA cycle).
  - Frame length = 4*(10*CLKS_PER_BIT+1) cycles, from the CARREGA edge to the FIM edge.
- enviar=1 while ocupado=1 sets pendente. This is a one-deep queue: further requests merge into it.
- An enviar asserted in the FIM cycle is treated as pendente and also handled.
- Inputs are sampled only at snapshot time; changes during transmission do not affect the frame in flight.
- Bit counter: 4 bits. Baud counter: clog2(CLKS_PER_BIT) bits, reloaded each bit, with no drift across bits.

Decomposition:
- Package smart_cargo_pkg holds:
  - frame-FSM state encodings;
  - FRAME_LEN=4;
  - the header constant;
  - a function for the b3 checksum.
- Sub-module uart_tx_byte(clock, reset, partida, dado[7:0], saida_serial, pronto_byte) owns the baud counter, bit counter and shift register.
  - Its internal states are IDLE, START, DATA, STOP.
  - pronto_byte pulses in the last cycle of the stop bit.
  - It can be reused by future TX paths.

Test Plan:
- Reset then idle 100 cycles -> TX=1, ocupado=0, pronto=0 throughout.
- CLKS_PER_BIT=4; andarAtual=2, proxParada=3, motorSubindo=1, estado_mov=5; pulse enviar -> bytes 0x53, 0x4E, 0x05, 0x18 decoded LSB-first. Start bit at edge N+2; frame lasts 164 cycles; a single pronto pulse.
- emergencia=1, motorDescendo=1, andarAtual=0, proxParada=0, estado_mov=0xF -> b1=0xA0, b2=0x0F, b3=0xFC.
- enviar pulsed twice during a frame, with andarAtual changed 1→3 mid-frame -> exactly two frames back-to-back. The first frame carries 1 and the second carries 3; there is 1 idle cycle between frames' bytes, and 2 pronto pulses.
- reset=0 asserted mid-way through the data bits of b1 -> TX=1 asynchronously, ocupado=0, pendente cleared. After release, a new enviar produces a complete correct frame.
- Bit timing check with CLKS_PER_BIT=434 -> every bit edge is exactly 434 cycles apart across all 40 bits (±0).

Source files
------------

// File: rtl/smart_cargo_pkg.sv
// Shared constants, types and frame-building helpers for the cargo-elevator status
// transmitter.
package smart_cargo_pkg;

   localparam int         FRAME_LEN     = 4;
   localparam logic [7:0] FRAME_HDR_DEF = 8'h53;

   // Frame-FSM encodings; these values appear directly on db_estado.
   localparam logic [2:0] ST_OCIOSO  = 3'd0;
   localparam logic [2:0] ST_CARREGA = 3'd1;
   localparam logic [2:0] ST_ESPERA  = 3'd2;
   localparam logic [2:0] ST_FIM     = 3'd3;

   typedef logic [FRAME_LEN-1:0][7:0] frame_t;

   typedef struct packed {
      logic       emergencia;
      logic       motorSubindo;
      logic       motorDescendo;
      logic [1:0] proxParada;
      logic [1:0] andarAtual;
      logic [3:0] estado_mov;
   } status_t;

   function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b2);
      return b0 ^ b1 ^ b2;
   endfunction

   function automatic frame_t build_frame(input logic [7:0] hdr, input status_t s);
      logic [7:0] b1;
      logic [7:0] b2;
      b1 = {s.emergencia, s.motorSubindo, s.motorDescendo, 1'b0, s.proxParada, s.andarAtual};
      b2 = {4'h0, s.estado_mov};
      return {frame_checksum(hdr, b1, b2), b2, b1, hdr};
   endfunction

endpackage

// File: rtl/smart_cargo_tx_status_if.sv
// Status-request and serial-output signal bundle between the elevator datapath and
// the status transmitter.
interface smart_cargo_tx_status_if;
   // enviar is a level request sampled every clock; ocupado covers the whole span from
   // acceptance to the final frame, pronto pulses once per completed frame, and a
   // request seen while ocupado=1 is merged into a single queued frame.
   logic       enviar;
   logic [1:0] andarAtual;
   logic [1:0] proxParada;
   logic       motorSubindo;
   logic       motorDescendo;
   logic       emergencia;
   logic [3:0] estado_mov;
   logic       TX;
   logic       ocupado;
   logic       pronto;
   logic [2:0] db_estado;

   modport master (
      output enviar, andarAtual, proxParada, motorSubindo, motorDescendo, emergencia,
             estado_mov,
      input  TX, ocupado, pronto, db_estado
   );

   modport slave (
      input  enviar, andarAtual, proxParada, motorSubindo, motorDescendo, emergencia,
             estado_mov,
      output TX, ocupado, pronto, db_estado
   );
endinterface

// File: rtl/smart_cargo_tx_status_uart_tx_byte.sv
// Single-byte UART 8N1 serialiser: start bit, 8 data bits LSB first, stop bit.
// Reusable by any TX path that feeds it bytes with a partida strobe.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [7:0] dado,
   output logic       saida_serial,
   output logic       pronto_byte
);

   localparam int             BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]    st_q, st_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          saida_q, saida_d;
   logic          bit_end;

   // The baud counter restarts at every bit boundary, so bit widths never accumulate drift.
   assign bit_end = (baud_q == BAUD_MAX);

   always_comb begin
      st_d    = st_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      saida_d = saida_q;
      case (st_q)
         IDLE: begin
            if (partida) begin
               shift_d = dado;
               saida_d = 1'b0;
               baud_d  = '0;
               st_d    = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               saida_d = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = 4'd0;
               st_d    = DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 4'd7) begin
                  saida_d = 1'b1;
                  st_d    = STOP;
               end else begin
                  saida_d = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               st_d   = IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q    <= IDLE;
         baud_q  <= '0;
         bit_q   <= 4'd0;
         shift_q <= 8'h00;
         saida_q <= 1'b1;
      end else begin
         st_q    <= st_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         saida_q <= saida_d;
      end
   end

   assign saida_serial = saida_q;
   assign pronto_byte  = (st_q == STOP) && bit_end;

endmodule

// File: rtl/smart_cargo_tx_status.sv
// Cargo-elevator status transmitter: snapshots floor/stop/motor/emergency/motion state
// on request and sends a 4-byte checksummed frame over the UART line.
module smart_cargo_tx_status
   import smart_cargo_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] FRAME_HDR    = FRAME_HDR_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   smart_cargo_tx_status_if.slave  bus
);

   logic [2:0] st_q, st_d;
   logic [1:0] idx_q, idx_d;
   frame_t     frame_q, frame_d;
   logic       pendente_q, pendente_d;
   logic       enviar_q;
   status_t    snap_s;
   frame_t     snap;
   logic       partida;
   logic       pronto_byte;
   logic       saida;

   assign snap_s = {bus.emergencia, bus.motorSubindo, bus.motorDescendo,
                    bus.proxParada, bus.andarAtual, bus.estado_mov};
   assign snap   = build_frame(FRAME_HDR, snap_s);

   // The registered request is what puts the start bit two edges after enviar is sampled.
   always_comb begin
      st_d       = st_q;
      idx_d      = idx_q;
      frame_d    = frame_q;
      pendente_d = pendente_q;
      case (st_q)
         ST_OCIOSO: begin
            if (enviar_q) begin
               frame_d = snap;
               idx_d   = 2'd0;
               st_d    = ST_CARREGA;
            end
         end
         ST_CARREGA: begin
            if (enviar_q) pendente_d = 1'b1;
            st_d = ST_ESPERA;
         end
         ST_ESPERA: begin
            if (enviar_q) pendente_d = 1'b1;
            if (pronto_byte) begin
               if (idx_q != 2'(FRAME_LEN - 1)) begin
                  idx_d = idx_q + 2'd1;
                  st_d  = ST_CARREGA;
               end else begin
                  st_d = ST_FIM;
               end
            end
         end
         ST_FIM: begin
            if (pendente_q || enviar_q) begin
               pendente_d = 1'b0;
               frame_d    = snap;
               idx_d      = 2'd0;
               st_d       = ST_CARREGA;
            end else begin
               st_d = ST_OCIOSO;
            end
         end
         default: st_d = ST_OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q       <= ST_OCIOSO;
         idx_q      <= 2'd0;
         frame_q    <= '0;
         pendente_q <= 1'b0;
         enviar_q   <= 1'b0;
      end else begin
         st_q       <= st_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         pendente_q <= pendente_d;
         enviar_q   <= bus.enviar;
      end
   end

   assign partida = (st_q == ST_CARREGA);

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .clock        (clock),
      .reset        (reset),
      .partida      (partida),
      .dado         (frame_q[idx_q]),
      .saida_serial (saida),
      .pronto_byte  (pronto_byte)
   );

   assign bus.TX        = saida;
   assign bus.pronto    = (st_q == ST_FIM);
   assign bus.ocupado   = enviar_q || (st_q == ST_CARREGA) || (st_q == ST_ESPERA) ||
                          ((st_q == ST_FIM) && pendente_q);
   assign bus.db_estado = st_q;

endmodule

// File: tb/tb_smart_cargo_tx_status.sv
// Directed bench for smart_cargo_tx_status: a fast-baud instance for frame content and
// queueing, and a 434-clock instance for exact bit timing.
module tb_smart_cargo_tx_status;

   localparam int MAXREC = 17400;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic tx_rec [0:MAXREC-1];

   smart_cargo_tx_status_if bus_a ();
   smart_cargo_tx_status_if bus_b ();

   smart_cargo_tx_status #(.CLKS_PER_BIT(4), .FRAME_HDR(8'h53)) dut_a (
      .clock (clock), .reset (reset), .bus (bus_a)
   );
   smart_cargo_tx_status #(.CLKS_PER_BIT(434), .FRAME_HDR(8'h53)) dut_b (
      .clock (clock), .reset (reset), .bus (bus_b)
   );

   always #5 clock = ~clock;

   // Expected line level at negedge j after the edge that sampled enviar; fr = {b3,b2,b1,b0}.
   function automatic logic exp_tx(input int j, input logic [31:0] fr, input int cpb);
      int rel, per, i, off, bn;
      if (j < 2) return 1'b1;
      rel = j - 2;
      per = 10 * cpb + 1;
      i   = rel / per;
      off = rel % per;
      if (i > 3) return 1'b1;
      if (off >= 10 * cpb) return 1'b1;
      bn = off / cpb;
      if (bn == 0) return 1'b0;
      if (bn == 9) return 1'b1;
      return fr[i*8 + bn - 1];
   endfunction

   function automatic logic [7:0] decode_byte(input int base, input int i, input int cpb);
      logic [7:0] r;
      int start;
      start = base + 2 + i * (10 * cpb + 1);
      for (int k = 0; k < 8; k++) r[k] = tx_rec[start + (k + 1) * cpb + cpb / 2];
      return r;
   endfunction

   task automatic set_status_a(input logic [1:0] a, input logic [1:0] p, input logic su,
                               input logic de, input logic em, input logic [3:0] est);
      bus_a.andarAtual = a; bus_a.proxParada = p; bus_a.motorSubindo = su;
      bus_a.motorDescendo = de; bus_a.emergencia = em; bus_a.estado_mov = est;
   endtask

   task automatic test_reset();
      int bad_tx, bad_oc, bad_pr;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_vec++; if (bus_a.TX !== 1'b1) begin n_err++; $display("FAIL rst_tx: got %b expected 1", bus_a.TX); end
      n_vec++; if (bus_a.ocupado !== 1'b0) begin n_err++; $display("FAIL rst_ocupado: got %b expected 0", bus_a.ocupado); end
      n_vec++; if (bus_a.pronto !== 1'b0) begin n_err++; $display("FAIL rst_pronto: got %b expected 0", bus_a.pronto); end
      n_vec++; if (bus_a.db_estado !== 3'd0) begin n_err++; $display("FAIL rst_db_estado: got %0d expected 0", bus_a.db_estado); end
      n_vec++; if (bus_b.TX !== 1'b1) begin n_err++; $display("FAIL rst_tx_b: got %b expected 1", bus_b.TX); end
      reset = 1'b1;
      bad_tx = 0; bad_oc = 0; bad_pr = 0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clock);
         if (bus_a.TX !== 1'b1) bad_tx++;
         if (bus_a.ocupado !== 1'b0) bad_oc++;
         if (bus_a.pronto !== 1'b0) bad_pr++;
      end
      n_vec++; if (bad_tx != 0) begin n_err++; $display("FAIL idle_tx: %0d cycles low, expected 0", bad_tx); end
      n_vec++; if (bad_oc != 0) begin n_err++; $display("FAIL idle_ocupado: %0d cycles high, expected 0", bad_oc); end
      n_vec++; if (bad_pr != 0) begin n_err++; $display("FAIL idle_pronto: %0d cycles high, expected 0", bad_pr); end
   endtask

   task automatic test_basic_frame();
      logic [31:0] fr = 32'h18054E53;
      logic [7:0]  got;
      logic [2:0]  db1, db2, db165;
      logic        oc164, oc165;
      int werr = 0, fj = -1, np = 0, pj = -1;
      set_status_a(2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 4'h5);
      @(negedge clock); bus_a.enviar = 1'b1;
      for (int j = 0; j < 200; j++) begin
         @(negedge clock);
         if (j == 0) bus_a.enviar = 1'b0;
         tx_rec[j] = bus_a.TX;
         if (bus_a.TX !== exp_tx(j, fr, 4)) begin werr++; if (fj < 0) fj = j; end
         if (bus_a.pronto === 1'b1) begin np++; pj = j; end
         if (j == 1) db1 = bus_a.db_estado;
         if (j == 2) db2 = bus_a.db_estado;
         if (j == 165) db165 = bus_a.db_estado;
         if (j == 164) oc164 = bus_a.ocupado;
         if (j == 165) oc165 = bus_a.ocupado;
      end
      n_vec++; if (tx_rec[1] !== 1'b1) begin n_err++; $display("FAIL basic_pre_start: got %b expected 1", tx_rec[1]); end
      n_vec++; if (tx_rec[2] !== 1'b0) begin n_err++; $display("FAIL basic_start_edge: got %b expected 0", tx_rec[2]); end
      for (int i = 0; i < 4; i++) begin
         got = decode_byte(0, i, 4);
         n_vec++;
         if (got !== fr[i*8 +: 8]) begin n_err++; $display("FAIL basic_byte%0d: got %02h expected %02h", i, got, fr[i*8 +: 8]); end
      end
      n_vec++; if (werr != 0) begin n_err++; $display("FAIL basic_wave: %0d bad cycles (first %0d), expected 0", werr, fj); end
      n_vec++; if (np != 1) begin n_err++; $display("FAIL basic_pronto_count: got %0d expected 1", np); end
      n_vec++; if (pj != 165) begin n_err++; $display("FAIL basic_frame_len: pronto at %0d expected 165", pj); end
      n_vec++; if (oc164 !== 1'b1) begin n_err++; $display("FAIL basic_ocupado_busy: got %b expected 1", oc164); end
      n_vec++; if (oc165 !== 1'b0) begin n_err++; $display("FAIL basic_ocupado_fim: got %b expected 0", oc165); end
      n_vec++; if (db1 !== 3'd1) begin n_err++; $display("FAIL basic_db_carrega: got %0d expected 1", db1); end
      n_vec++; if (db2 !== 3'd2) begin n_err++; $display("FAIL basic_db_espera: got %0d expected 2", db2); end
      n_vec++; if (db165 !== 3'd3) begin n_err++; $display("FAIL basic_db_fim: got %0d expected 3", db165); end
   endtask

   task automatic test_emergency();
      logic [31:0] fr = 32'hFC0FA053;
      logic [7:0]  got;
      int werr = 0, fj = -1, np = 0;
      set_status_a(2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'hF);
      @(negedge clock); bus_a.enviar = 1'b1;
      for (int j = 0; j < 180; j++) begin
         @(negedge clock);
         if (j == 0) bus_a.enviar = 1'b0;
         tx_rec[j] = bus_a.TX;
         if (bus_a.TX !== exp_tx(j, fr, 4)) begin werr++; if (fj < 0) fj = j; end
         if (bus_a.pronto === 1'b1) np++;
      end
      for (int i = 0; i < 4; i++) begin
         got = decode_byte(0, i, 4);
         n_vec++;
         if (got !== fr[i*8 +: 8]) begin n_err++; $display("FAIL emerg_byte%0d: got %02h expected %02h", i, got, fr[i*8 +: 8]); end
      end
      n_vec++; if (werr != 0) begin n_err++; $display("FAIL emerg_wave: %0d bad cycles (first %0d), expected 0", werr, fj); end
      n_vec++; if (np != 1) begin n_err++; $display("FAIL emerg_pronto_count: got %0d expected 1", np); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] f1 = 32'h1B054D53;
      logic [31:0] f2 = 32'h19054F53;
      logic [7:0]  got;
      logic        oc165, oc_end;
      logic        e;
      int werr = 0, fj = -1, np = 0, p1 = -1, p2 = -1;
      set_status_a(2'd1, 2'd3, 1'b1, 1'b0, 1'b0, 4'h5);
      @(negedge clock); bus_a.enviar = 1'b1;
      for (int j = 0; j < 400; j++) begin
         @(negedge clock);
         if (j == 0 || j == 41 || j == 101) bus_a.enviar = 1'b0;
         if (j == 40 || j == 100) bus_a.enviar = 1'b1;
         if (j == 70) bus_a.andarAtual = 2'd3;
         tx_rec[j] = bus_a.TX;
         e = (j < 165) ? exp_tx(j, f1, 4) : exp_tx(j - 165, f2, 4);
         if (bus_a.TX !== e) begin werr++; if (fj < 0) fj = j; end
         if (bus_a.pronto === 1'b1) begin np++; if (p1 < 0) p1 = j; else p2 = j; end
         if (j == 165) oc165 = bus_a.ocupado;
         if (j == 399) oc_end = bus_a.ocupado;
      end
      for (int i = 0; i < 4; i++) begin
         got = decode_byte(0, i, 4);
         n_vec++;
         if (got !== f1[i*8 +: 8]) begin n_err++; $display("FAIL b2b_f1_byte%0d: got %02h expected %02h", i, got, f1[i*8 +: 8]); end
         got = decode_byte(165, i, 4);
         n_vec++;
         if (got !== f2[i*8 +: 8]) begin n_err++; $display("FAIL b2b_f2_byte%0d: got %02h expected %02h", i, got, f2[i*8 +: 8]); end
      end
      n_vec++; if (werr != 0) begin n_err++; $display("FAIL b2b_wave: %0d bad cycles (first %0d), expected 0", werr, fj); end
      n_vec++; if (np != 2) begin n_err++; $display("FAIL b2b_pronto_count: got %0d expected 2", np); end
      n_vec++; if (p1 != 165) begin n_err++; $display("FAIL b2b_pronto1: at %0d expected 165", p1); end
      n_vec++; if (p2 != 330) begin n_err++; $display("FAIL b2b_pronto2: at %0d expected 330", p2); end
      n_vec++; if (oc165 !== 1'b1) begin n_err++; $display("FAIL b2b_ocupado_fim: got %b expected 1", oc165); end
      n_vec++; if (oc_end !== 1'b0) begin n_err++; $display("FAIL b2b_ocupado_end: got %b expected 0", oc_end); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] fr = 32'h7D092753;
      logic [7:0]  got;
      int bad = 0, werr = 0, fj = -1, np = 0;
      set_status_a(2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 4'h5);
      @(negedge clock); bus_a.enviar = 1'b1;
      for (int j = 0; j <= 48; j++) begin
         @(negedge clock);
         if (j == 0 || j == 21) bus_a.enviar = 1'b0;
         if (j == 20) bus_a.enviar = 1'b1;
      end
      n_vec++; if (bus_a.TX !== 1'b0) begin n_err++; $display("FAIL mid_pre_reset_tx: got %b expected 0", bus_a.TX); end
      reset = 1'b0;
      #1;
      n_vec++; if (bus_a.TX !== 1'b1) begin n_err++; $display("FAIL mid_async_tx: got %b expected 1", bus_a.TX); end
      n_vec++; if (bus_a.ocupado !== 1'b0) begin n_err++; $display("FAIL mid_async_ocupado: got %b expected 0", bus_a.ocupado); end
      n_vec++; if (bus_a.db_estado !== 3'd0) begin n_err++; $display("FAIL mid_async_db: got %0d expected 0", bus_a.db_estado); end
      repeat (3) @(negedge clock);
      reset = 1'b1;
      for (int j = 0; j < 300; j++) begin
         @(negedge clock);
         if (bus_a.TX !== 1'b1 || bus_a.ocupado !== 1'b0 || bus_a.pronto !== 1'b0) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL mid_pendente_cleared: %0d active cycles, expected 0", bad); end
      set_status_a(2'd3, 2'd1, 1'b0, 1'b1, 1'b0, 4'h9);
      @(negedge clock); bus_a.enviar = 1'b1;
      for (int j = 0; j < 180; j++) begin
         @(negedge clock);
         if (j == 0) bus_a.enviar = 1'b0;
         tx_rec[j] = bus_a.TX;
         if (bus_a.TX !== exp_tx(j, fr, 4)) begin werr++; if (fj < 0) fj = j; end
         if (bus_a.pronto === 1'b1) np++;
      end
      for (int i = 0; i < 4; i++) begin
         got = decode_byte(0, i, 4);
         n_vec++;
         if (got !== fr[i*8 +: 8]) begin n_err++; $display("FAIL mid_after_byte%0d: got %02h expected %02h", i, got, fr[i*8 +: 8]); end
      end
      n_vec++; if (werr != 0) begin n_err++; $display("FAIL mid_after_wave: %0d bad cycles (first %0d), expected 0", werr, fj); end
      n_vec++; if (np != 1) begin n_err++; $display("FAIL mid_after_pronto: got %0d expected 1", np); end
   endtask

   task automatic test_bit_timing();
      logic [31:0] fr = 32'hFC0FA053;
      logic [7:0]  got;
      int werr = 0, fj = -1, np = 0, pj = -1;
      bus_b.andarAtual = 2'd0; bus_b.proxParada = 2'd0; bus_b.motorSubindo = 1'b0;
      bus_b.motorDescendo = 1'b1; bus_b.emergencia = 1'b1; bus_b.estado_mov = 4'hF;
      @(negedge clock); bus_b.enviar = 1'b1;
      for (int j = 0; j < MAXREC; j++) begin
         @(negedge clock);
         if (j == 0) bus_b.enviar = 1'b0;
         tx_rec[j] = bus_b.TX;
         if (bus_b.TX !== exp_tx(j, fr, 434)) begin werr++; if (fj < 0) fj = j; end
         if (bus_b.pronto === 1'b1) begin np++; pj = j; end
      end
      for (int i = 0; i < 4; i++) begin
         got = decode_byte(0, i, 434);
         n_vec++;
         if (got !== fr[i*8 +: 8]) begin n_err++; $display("FAIL timing_byte%0d: got %02h expected %02h", i, got, fr[i*8 +: 8]); end
      end
      n_vec++; if (werr != 0) begin n_err++; $display("FAIL timing_bit_edges: %0d bad cycles (first %0d), expected 0", werr, fj); end
      n_vec++; if (np != 1) begin n_err++; $display("FAIL timing_pronto_count: got %0d expected 1", np); end
      n_vec++; if (pj != 17365) begin n_err++; $display("FAIL timing_frame_len: pronto at %0d expected 17365", pj); end
   endtask

   initial begin
      bus_a.enviar = 1'b0;
      bus_b.enviar = 1'b0;
      set_status_a(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
      bus_b.andarAtual = 2'd0; bus_b.proxParada = 2'd0; bus_b.motorSubindo = 1'b0;
      bus_b.motorDescendo = 1'b0; bus_b.emergencia = 1'b0; bus_b.estado_mov = 4'h0;
      test_reset();
      test_basic_frame();
      test_emergency();
      test_back_to_back();
      test_reset_mid_frame();
      test_bit_timing();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
